// File: rtl/matmul_seq_ctrl.sv
// Loads two 4x4 byte matrices from UART bytes, computes C = A x B on one shared MAC
// (one product term per cycle), then streams C out over a valid/ready handshake on request.
module matmul_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              start_tx,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic [3:0]        out_idx,
  input  logic              out_ready,
  output logic [5:0]        byte_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;
  localparam int         PROD_W    = 2 * DATA_W;

  logic [1:0]        state;
  logic [DATA_W-1:0] a_mat [16];
  logic [DATA_W-1:0] b_mat [16];
  logic [ACC_W-1:0]  c_mat [16];

  logic [1:0]        row;
  logic [1:0]        col;
  logic [1:0]        k;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;

  // The only multiplier: A[row][k] * B[k][col], selected by the loop counters.
  assign prod     = PROD_W'(a_mat[{row, k}]) * PROD_W'(b_mat[{k, col}]);
  assign sum      = acc + ACC_W'(prod);
  assign out_data = c_mat[out_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      row       <= '0;
      col       <= '0;
      k         <= '0;
      acc       <= '0;
      for (int i = 0; i < 16; i++) begin
        a_mat[i] <= '0;
        b_mat[i] <= '0;
        c_mat[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (start_tx) err <= 1'b1;
          if (rx_valid) begin
            // Bytes 0-15 fill A, 16-31 fill B, both row-major.
            if (!byte_cnt[4]) a_mat[byte_cnt[3:0]] <= rx_byte;
            else              b_mat[byte_cnt[3:0]] <= rx_byte;
            byte_cnt <= byte_cnt + 6'd1;
            if (byte_cnt == 6'd31) begin
              state <= S_COMPUTE;
              busy  <= 1'b1;
              row   <= '0;
              col   <= '0;
              k     <= '0;
              acc   <= '0;
            end
          end
        end

        S_COMPUTE: begin
          if (rx_valid || start_tx) err <= 1'b1;
          if (k != 2'd3) begin
            acc <= sum;
            k   <= k + 2'd1;
          end else begin
            c_mat[{row, col}] <= sum;
            acc               <= '0;
            k                 <= '0;
            {row, col}        <= {row, col} + 4'd1;
            if ({row, col} == 4'd15) begin
              state <= S_HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (start_tx) begin
            // A simultaneous byte loses to the send request and is flagged.
            if (rx_valid) err <= 1'b1;
            state     <= S_SEND;
            done      <= 1'b0;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else if (rx_valid) begin
            a_mat[0] <= rx_byte;
            byte_cnt <= 6'd1;
            state    <= S_LOAD;
            done     <= 1'b0;
          end
        end

        S_SEND: begin
          if (rx_valid) err <= 1'b1;
          if (out_ready) begin
            if (out_idx == 4'd15) begin
              state     <= S_HOLD;
              out_valid <= 1'b0;
              out_idx   <= '0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + 4'd1;
            end
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: loads known matrices, checks timing, streamed
// results, stall stability, error flagging and mid-compute reset.
module tb_matmul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        start_tx;
  logic        out_valid;
  logic [17:0] out_data;
  logic [3:0]  out_idx;
  logic        out_ready;
  logic [5:0]  byte_cnt;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mat_a [16];
  logic [7:0]  mat_b [16];
  logic [31:0] exp_c [16];

  matmul_seq_ctrl #(.DATA_W(8), .ACC_W(18)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .start_tx(start_tx), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_ready(out_ready), .byte_cnt(byte_cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic load_mats(input int from);
    for (int i = from; i < 32; i++)
      send_byte(i < 16 ? mat_a[i] : mat_b[i-16]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idx"},   32'(out_idx),   32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_cnt"},   32'(byte_cnt),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // Requests a stream and checks all 16 transfers; stalls hold data and index.
  task automatic run_send(input string tag, input bit rand_ready);
    int          xfers = 0;
    int          cycles = 0;
    bit          stalled = 0;
    logic [17:0] prev_data = '0;
    logic [3:0]  prev_idx = '0;
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    check({tag, "_valid_rise"}, 32'(out_valid), 32'd1);
    while (xfers < 16 && cycles < 400) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!out_valid) begin
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd1);
        break;
      end
      if (stalled) begin
        check({tag, "_stall_data"}, 32'(out_data), 32'(prev_data));
        check({tag, "_stall_idx"},  32'(out_idx),  32'(prev_idx));
      end
      if (out_ready) begin
        check({tag, "_idx"},  32'(out_idx),  32'(xfers));
        check({tag, "_data"}, 32'(out_data), exp_c[xfers]);
        xfers++;
        stalled = 0;
      end else begin
        stalled   = 1;
        prev_data = out_data;
        prev_idx  = out_idx;
      end
      tick();
      cycles++;
    end
    out_ready = 1'b0;
    check({tag, "_xfers"}, 32'(xfers), 32'd16);
    if (!rand_ready) check({tag, "_cycles"}, 32'(cycles), 32'd16);
    check({tag, "_valid_end"}, 32'(out_valid), 32'd0);
    check({tag, "_idx_end"},   32'(out_idx),   32'd0);
    check({tag, "_done_end"},  32'(done),      32'd1);
  endtask

  task automatic set_ident_seq();
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      mat_b[i] = 8'(i + 1);
      exp_c[i] = 32'(i + 1);
    end
  endtask

  task automatic set_m_sq();
    logic [31:0] c_tab [16] = '{90, 100, 110, 120, 202, 228, 254, 280,
                                314, 356, 398, 440, 426, 484, 542, 600};
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 8'(i + 1);
      mat_b[i] = 8'(i + 1);
      exp_c[i] = c_tab[i];
    end
  endtask

  initial begin
    int nbusy;
    int first_done;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; start_tx = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Identity x 1..16
    set_ident_seq();
    for (int i = 0; i < 16; i++) send_byte(mat_a[i]);
    check("cnt_half", 32'(byte_cnt), 32'd16);
    load_mats(16);
    check("cnt_full", 32'(byte_cnt), 32'd32);
    check("busy_on",  32'(busy), 32'd1);
    wait_done();
    run_send("ident", 1'b0);
    check("ident_err", 32'(err), 32'd0);

    // All 0xFF: 33rd byte from S_HOLD restarts the load
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 8'hFF; mat_b[i] = 8'hFF; exp_c[i] = 32'd260100;
    end
    send_byte(mat_a[0]);
    check("reload_cnt",  32'(byte_cnt), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_busy", 32'(busy), 32'd0);
    load_mats(1);
    nbusy = 0; first_done = 0;
    for (int i = 1; i <= 70; i++) begin
      if (busy) nbusy++;
      if (done && first_done == 0) first_done = i;
      tick();
    end
    check("busy_cycles", 32'(nbusy), 32'd64);
    check("done_cycle",  32'(first_done), 32'd65);
    run_send("ff_a", 1'b0);
    run_send("ff_b", 1'b0);

    // M x M with random back-pressure
    set_m_sq();
    load_mats(0);
    wait_done();
    run_send("msq", 1'b1);

    // Reset at compute cycle 30, then reload
    load_mats(0);
    for (int i = 0; i < 29; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    load_mats(0);
    wait_done();
    run_send("after_rst", 1'b0);

    // Protocol errors: start_tx in S_LOAD, byte in S_COMPUTE
    reset = 1'b1; tick(); reset = 1'b0;
    start_tx = 1'b1; tick(); start_tx = 1'b0;
    check("err_load",     32'(err), 32'd1);
    check("err_load_cnt", 32'(byte_cnt), 32'd0);
    check("err_load_st",  32'(busy), 32'd0);
    set_ident_seq();
    load_mats(0);
    tick(); tick();
    send_byte(8'h55);
    check("err_comp_cnt", 32'(byte_cnt), 32'd32);
    check("err_comp",     32'(err), 32'd1);
    wait_done();
    run_send("err_res", 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
